// File: rtl/gups_pkg.sv
// gups_pkg: shared FSM state encoding, default LFSR taps and the LFSR step function
package gups_pkg;
  typedef enum logic [2:0] {IDLE, GEN, RD, RWAIT, WR, DONE} state_t;
  localparam int LFSR_MAXW = 64;
  localparam logic [LFSR_MAXW-1:0] POLY_DEFAULT = 64'h7;
  // Galois step for any width up to LFSR_MAXW; bits above w are forced to zero
  function automatic logic [LFSR_MAXW-1:0] lfsr_next(input logic [LFSR_MAXW-1:0] s,
                                                     input logic [LFSR_MAXW-1:0] poly,
                                                     input int unsigned w);
    logic [LFSR_MAXW-1:0] m;
    logic [LFSR_MAXW-1:0] t;
    m = (w >= LFSR_MAXW) ? '1 : ((LFSR_MAXW'(1) << w) - LFSR_MAXW'(1));
    t = s >> (w - 1);
    return ((s << 1) ^ (t[0] ? poly : '0)) & m;
  endfunction
endpackage

// File: rtl/gups_lfsr.sv
// gups_lfsr: Galois LFSR producing the random update values; a zero seed loads as 1
module gups_lfsr import gups_pkg::*; #(
  parameter int DW = 64,
  parameter logic [DW-1:0] POLY = DW'(POLY_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] seed_i,
  output logic [DW-1:0] state_o,
  output logic [DW-1:0] next_o
);
  logic [DW-1:0] ran_q;
  assign next_o  = DW'(lfsr_next(LFSR_MAXW'(ran_q), LFSR_MAXW'(POLY), DW));
  assign state_o = ran_q;
  // load the seed on run start, advance once per update
  always_ff @(posedge clk) begin
    if (reset) ran_q <= '0;
    else if (load_i) ran_q <= (seed_i == '0) ? DW'(1) : seed_i;
    else if (step_i) ran_q <= next_o;
  end
endmodule

// File: rtl/gups_engine.sv
// gups_engine: GUPS read-modify-write engine; define GUPS_STATS_EN to add the cycle_count run timer
module gups_engine import gups_pkg::*; #(
  parameter int DW = 64,
  parameter int AW = 32,
  parameter int CW = 32,
  parameter logic [DW-1:0] POLY = DW'(POLY_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] range_mask,
  input  logic [CW-1:0] num_updates,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] update_count,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
`ifdef GUPS_STATS_EN
  ,
  output logic [CW-1:0] cycle_count
`endif
);
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, mask_q, mask_d;
  logic [DW-1:0] wdata_q, wdata_d, ran, ran_nxt;
  logic [CW-1:0] cnt_q, cnt_d, num_q, num_d;
  logic          accept;
  assign accept       = start && (state_q == IDLE || state_q == DONE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign update_count = cnt_q;
  gups_lfsr #(.DW(DW), .POLY(POLY)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .step_i  (state_q == GEN),
    .seed_i  (seed),
    .state_o (ran),
    .next_o  (ran_nxt)
  );
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      mask_q  <= mask_d;
    end
  end
  // next state: one RMW per GEN..WR loop, zero-length runs finish immediately
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (num_updates == '0) ? DONE : GEN;
      GEN:        state_d = RD;
      RD:         if (mem_ready) state_d = RWAIT;
      RWAIT:      if (mem_rvalid) state_d = WR;
      WR:         if (mem_ready) state_d = (cnt_q + CW'(1) == num_q) ? DONE : GEN;
      default:    state_d = IDLE;
    endcase
  end
  // outputs decoded from state; request fields come from registers so they hold while stalled
  always_comb begin
    busy    = state_q == GEN || state_q == RD || state_q == RWAIT || state_q == WR;
    done    = state_q == DONE;
    mem_req = state_q == RD || state_q == WR;
    mem_wr  = state_q == WR;
  end
  // datapath next values: config captured only on an accepted start
  always_comb begin
    num_d   = accept ? num_updates : num_q;
    mask_d  = accept ? range_mask : mask_q;
    cnt_d   = accept ? '0 : (state_q == WR && mem_ready) ? cnt_q + CW'(1) : cnt_q;
    addr_d  = (state_q == GEN) ? AW'(ran_nxt) & mask_q : addr_q;
    wdata_d = (state_q == RWAIT && mem_rvalid) ? mem_rdata ^ ran : wdata_q;
  end
`ifdef GUPS_STATS_EN
  logic [CW-1:0] ccnt_q, ccnt_d;
  assign cycle_count = ccnt_q;
  // run timer: cleared on start, counts busy cycles, holds once done
  always_comb ccnt_d = accept ? '0 : busy ? ccnt_q + CW'(1) : ccnt_q;
  // run timer register
  always_ff @(posedge clk) begin
    if (reset) ccnt_q <= '0;
    else ccnt_q <= ccnt_d;
  end
`endif
endmodule

// File: tb/tb_gups_engine.sv
// tb_gups_engine: scoreboard bench for gups_engine with a stallable memory model
module tb_gups_engine;
  localparam int DW = 64, AW = 32, CW = 32;
  logic clk = 0, reset = 1, start = 0;
  logic [DW-1:0] seed = '0;
  logic [AW-1:0] range_mask = '0;
  logic [CW-1:0] num_updates = '0;
  logic busy, done, mem_req, mem_wr;
  logic [CW-1:0] update_count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_ready = 0, mem_rvalid = 0;
  logic [DW-1:0] mem_rdata = '0;
`ifdef GUPS_STATS_EN
  logic [CW-1:0] cycle_count;
`endif
  gups_engine dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .seed         (seed),
    .range_mask   (range_mask),
    .num_updates  (num_updates),
    .busy         (busy),
    .done         (done),
    .update_count (update_count),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
`ifdef GUPS_STATS_EN
    ,
    .cycle_count  (cycle_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {bit wr; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
  txn_t exp_q[$];
  txn_t e;
  int tests = 0, fails = 0, req_cycles = 0, rc = 0;
  int stall_cfg = 0, rd_lat = 1, lat_left = 0, wait_cnt = 0;
  logic [DW-1:0] rdata_cfg = '0;
  bit rd_pending = 0, was_rd = 0, held = 0;
  logic h_wr;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  function automatic void push(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{wr, a, d});
  endfunction
  // memory model: grants after stall_cfg waiting cycles, read data rd_lat+1 cycles after acceptance
  always @(posedge clk) begin
    #1;
    if (mem_ready && was_rd) begin rd_pending = 1; lat_left = rd_lat; end
    mem_ready = 0;
    mem_rvalid = 0;
    if (reset) begin
      rd_pending = 0;
      wait_cnt = 0;
    end else begin
      if (rd_pending) begin
        if (lat_left == 0) begin mem_rvalid = 1; mem_rdata = rdata_cfg; rd_pending = 0; end
        else lat_left--;
      end
      if (mem_req) begin
        if (wait_cnt >= stall_cfg) begin mem_ready = 1; was_rd = !mem_wr; wait_cnt = 0; end
        else wait_cnt++;
      end
    end
  end
  // monitor: checks every accepted request against the scoreboard and request stability while stalled
  always @(negedge clk) begin
    if (reset) held = 0;
    else begin
      if (mem_req) req_cycles++;
      if (held && mem_req) begin
        chk("stable_addr", 64'(mem_addr), 64'(h_addr));
        chk("stable_wr", 64'(mem_wr), 64'(h_wr));
        if (h_wr) chk("stable_wdata", mem_wdata, h_data);
      end
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got wr=%0d addr=%0h, expected no request", mem_wr, mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("req_wr", 64'(mem_wr), 64'(e.wr));
          chk("req_addr", 64'(mem_addr), 64'(e.addr));
          if (e.wr) chk("req_wdata", mem_wdata, e.data);
        end
        held = 0;
      end else if (mem_req) begin
        held = 1; h_wr = mem_wr; h_addr = mem_addr; h_data = mem_wdata;
      end else held = 0;
    end
  end
  task automatic pulse_start(input logic [DW-1:0] s, input logic [AW-1:0] m, input logic [CW-1:0] n);
    @(negedge clk);
    seed = s; range_mask = m; num_updates = n; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string name);
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    chk(name, 64'(done), 64'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_req", 64'(mem_req), 0);
    chk("rst_wr", 64'(mem_wr), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", 64'(update_count), 0);
    reset = 0;
    // basic update from seed 1
    rdata_cfg = 64'h10;
    push(0, 2, 0); push(1, 2, 64'h12);
    pulse_start(64'd1, 'hFF, 1);
    wait_done("t1_done");
    chk("t1_count", 64'(update_count), 1);
    chk("t1_drained", 64'(exp_q.size()), 0);
    // zero seed behaves as seed 1
    push(0, 2, 0); push(1, 2, 64'h12);
    pulse_start(64'd0, 'hFF, 1);
    wait_done("t2_done");
    chk("t2_count", 64'(update_count), 1);
    chk("t2_drained", 64'(exp_q.size()), 0);
    // MSB set: feedback taps applied
    rdata_cfg = 64'h0;
    push(0, 7, 0); push(1, 7, 64'h7);
    pulse_start(64'h8000_0000_0000_0000, 'hF, 1);
    wait_done("t3_done");
    chk("t3_count", 64'(update_count), 1);
    chk("t3_drained", 64'(exp_q.size()), 0);
    // long stalls and an ignored start while busy
    stall_cfg = 10;
    rdata_cfg = 64'h100;
    push(0, 6, 0); push(1, 6, 64'h106);
    pulse_start(64'd3, 'hFF, 1);
    repeat (4) @(negedge clk);
    chk("t5_busy", 64'(busy), 1);
    pulse_start(64'd9, 'hF, 5);
    wait_done("t5_done");
    chk("t5_count", 64'(update_count), 1);
    chk("t5_drained", 64'(exp_q.size()), 0);
    stall_cfg = 0;
    // reset while waiting for read data, then a clean 3-update run
    rdata_cfg = 64'h5;
    push(0, 2, 0);
    pulse_start(64'd1, 'hFF, 3);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    for (int i = 0; i < 50 && mem_req; i++) @(negedge clk);
    chk("t6_in_rwait", 64'(busy && !mem_req), 1);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("t6_rst_busy", 64'(busy), 0);
    chk("t6_rst_count", 64'(update_count), 0);
    chk("t6_rst_req", 64'(mem_req), 0);
    reset = 0;
    chk("t6_aborted_drained", 64'(exp_q.size()), 0);
    push(0, 2, 0); push(1, 2, 64'h7);
    push(0, 4, 0); push(1, 4, 64'h1);
    push(0, 8, 0); push(1, 8, 64'hD);
    pulse_start(64'd1, 'hFF, 3);
    wait_done("t6_done");
    chk("t6_count", 64'(update_count), 3);
    chk("t6_drained", 64'(exp_q.size()), 0);
`ifdef GUPS_STATS_EN
    chk("t6_cycles", 64'(cycle_count), 15);
`endif
    // zero updates: straight to done, no traffic
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    rc = req_cycles;
    @(negedge clk);
    seed = 64'd1; range_mask = 'hFF; num_updates = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("t4_done", 64'(done), 1);
    chk("t4_busy", 64'(busy), 0);
    chk("t4_count", 64'(update_count), 0);
    repeat (3) @(negedge clk);
    chk("t4_no_req", 64'(req_cycles - rc), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
